// File: rtl/arith_pkg.sv
// Shared arithmetic types: adder FSM states and the WIDTH/CHUNK legality check.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit width_ok(input int width, input int chunk);
    return (width >= 1) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Operand/result handshake bundle for multicycle_adder; ovf exists only with SIGNED_OVF_EN.
interface multicycle_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SIGNED_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef SIGNED_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef SIGNED_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/multicycle_adder_chunk_add.sv
// Combinational CHUNK-bit ripple of full-adder cells; also exposes the carry into the top bit.
module chunk_add #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  logic carry;

  always_comb begin
    carry   = cin_i;
    c_msb_o = cin_i;
    sum_o   = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb_o = carry;
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/multicycle_adder.sv
// Sequential adder: CHUNK bits per clock through a registered carry, valid/ready on both sides.
// Define SIGNED_OVF_EN to add the signed-overflow output ovf.
module multicycle_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_adder_if.slave   bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
    $error("multicycle_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [31:0]        base;
  logic [CHUNK-1:0]   chunk_sum;
  logic               chunk_cout;

  assign base = 32'(idx_q) * CHUNK;

`ifdef SIGNED_OVF_EN
  logic ovf_q, ovf_d;
  logic chunk_msb;

  chunk_add #(.CHUNK(CHUNK)) u_chunk (
    .a_i     (a_q[base +: CHUNK]),
    .b_i     (b_q[base +: CHUNK]),
    .cin_i   (carry_q),
    .sum_o   (chunk_sum),
    .cout_o  (chunk_cout),
    .c_msb_o (chunk_msb)
  );
`else
  logic c_msb_unused;

  chunk_add #(.CHUNK(CHUNK)) u_chunk (
    .a_i     (a_q[base +: CHUNK]),
    .b_i     (b_q[base +: CHUNK]),
    .cin_i   (carry_q),
    .sum_o   (chunk_sum),
    .cout_o  (chunk_cout),
    .c_msb_o (c_msb_unused)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: CHUNK] = chunk_sum;
        carry_d = chunk_cout;
        idx_d   = idx_q + 1'b1;
        // The last chunk's carries define cout and the signed overflow.
        if (idx_q == IDX_W'(N - 1)) begin
          cout_d  = chunk_cout;
`ifdef SIGNED_OVF_EN
          ovf_d   = chunk_msb ^ chunk_cout;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef SIGNED_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder: WIDTH=8/CHUNK=2 scenarios plus WIDTH=4 exhaustive sweeps.
module tb_multicycle_adder;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  multicycle_adder_if #(.WIDTH(8)) if8  ();
  multicycle_adder_if #(.WIDTH(4)) if41 ();
  multicycle_adder_if #(.WIDTH(4)) if44 ();

  multicycle_adder #(.WIDTH(8), .CHUNK(2)) dut8  (.clk(clk), .rst(rst), .bus(if8));
  multicycle_adder #(.WIDTH(4), .CHUNK(1)) dut41 (.clk(clk), .rst(rst), .bus(if41));
  multicycle_adder #(.WIDTH(4), .CHUNK(4)) dut44 (.clk(clk), .rst(rst), .bus(if44));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    #2;
    checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", if8.in_ready); end
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", if8.out_valid); end
    checks++; if (if8.sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%02h exp=00", if8.sum); end
    checks++; if (if8.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%0b exp=0", if8.cout); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%0b exp=1", if8.in_ready); end
    checks++; if (if41.in_ready !== 1'b1 || if44.in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready_w4 got=%0b%0b exp=11", if41.in_ready, if44.in_ready);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                     input string name);
    int n;
    int lat;
    n = 0;
    while (!if8.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_timeout got=%0b exp=1", name, if8.in_ready); end
    if8.a = a; if8.b = b; if8.cin = cin; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0; if8.a = ~a; if8.b = ~b; if8.cin = ~cin;
    lat = 0;
    while (!if8.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 4) begin errors++; $display("FAIL %s_latency got=%0d exp=4", name, lat); end
    checks++; if (if8.sum !== exp_sum) begin errors++; $display("FAIL %s_sum got=%02h exp=%02h", name, if8.sum, exp_sum); end
    checks++; if (if8.cout !== exp_cout) begin errors++; $display("FAIL %s_cout got=%0b exp=%0b", name, if8.cout, exp_cout); end
`ifdef SIGNED_OVF_EN
    checks++; if (if8.ovf !== exp_ovf) begin errors++; $display("FAIL %s_ovf got=%0b exp=%0b", name, if8.ovf, exp_ovf); end
`endif
    checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL %s_busy_in_ready got=%0b exp=0", name, if8.in_ready); end
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain_valid got=%0b exp=0", name, if8.out_valid); end
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL %s_drain_ready got=%0b exp=1", name, if8.in_ready); end
  endtask

  task automatic test_basic();
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_plus_1");
    op8(8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0, "c8_plus_64_cin");
  endtask

  task automatic test_carry_chain();
    op8(8'h03, 8'h01, 1'b0, 8'h04, 1'b0, 1'b0, "chunk_carry");
    op8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "cin_only");
  endtask

  task automatic test_signed();
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "pos_ovf");
    op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "neg_ovf");
  endtask

  task automatic test_backpressure();
    int lat;
    if8.a = 8'hC8; if8.b = 8'h64; if8.cin = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 6; i++) begin
      checks++; if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%0b exp=1", i, if8.out_valid); end
      checks++; if (if8.sum !== 8'h2C) begin errors++; $display("FAIL bp_sum[%0d] got=%02h exp=2c", i, if8.sum); end
      checks++; if (if8.cout !== 1'b1) begin errors++; $display("FAIL bp_cout[%0d] got=%0b exp=1", i, if8.cout); end
      checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, if8.in_ready); end
      @(posedge clk); #1;
    end
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%0b exp=0", if8.out_valid); end
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", if8.in_ready); end
  endtask

  task automatic test_reset_mid_run();
    if8.a = 8'h57; if8.b = 8'h23; if8.cin = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (if8.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%0b exp=0", if8.in_ready); end
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%0b exp=0", if8.out_valid); end
    checks++; if (if8.sum !== 8'h00) begin errors++; $display("FAIL midrst_sum got=%02h exp=00", if8.sum); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready got=%0b exp=1", if8.in_ready); end
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_release_valid got=%0b exp=0", if8.out_valid); end
    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int n;
    bit prev_valid;
    prev_valid = 1'b0;
    if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0;
    if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (if8.in_ready) acc.push_back(cyc);
      if (if8.out_valid) begin
        checks++; if (if8.sum !== 8'h46) begin errors++; $display("FAIL b2b_sum[%0d] got=%02h exp=46", cyc, if8.sum); end
        checks++; if (prev_valid) begin errors++; $display("FAIL b2b_done_len[%0d] got=2+ cycles exp=1", cyc); end
      end
      prev_valid = if8.out_valid;
      @(posedge clk); #1;
    end
    if8.in_valid = 1'b0;
    checks++;
    if (acc.size() < 2) begin
      errors++; $display("FAIL b2b_accepts got=%0d exp>=2", acc.size());
    end else if (acc[1] - acc[0] != 6) begin
      errors++; $display("FAIL b2b_interval got=%0d exp=6", acc[1] - acc[0]);
    end
    n = 0;
    while (!if8.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if8.out_ready = 1'b0;
    checks++; if (if8.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_settle got=%0b exp=1", if8.in_ready); end
  endtask

  task automatic test_sweep_w4();
    int lat41, lat44;
    logic [4:0] s41, s44, exp_v;
    if41.out_ready = 1'b1; if44.out_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          if41.a = 4'(a); if41.b = 4'(b); if41.cin = 1'(c);
          if44.a = 4'(a); if44.b = 4'(b); if44.cin = 1'(c);
          if41.in_valid = 1'b1; if44.in_valid = 1'b1;
          @(posedge clk); #1;
          if41.in_valid = 1'b0; if44.in_valid = 1'b0;
          lat41 = 0; lat44 = 0; s41 = '0; s44 = '0;
          for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (if41.out_valid && lat41 == 0) begin lat41 = k; s41 = {if41.cout, if41.sum}; end
            if (if44.out_valid && lat44 == 0) begin lat44 = k; s44 = {if44.cout, if44.sum}; end
          end
          exp_v = 5'(a + b + c);
          checks++; if (lat41 != 4) begin errors++; $display("FAIL sw41_latency a=%0d b=%0d c=%0d got=%0d exp=4", a, b, c, lat41); end
          checks++; if (lat44 != 1) begin errors++; $display("FAIL sw44_latency a=%0d b=%0d c=%0d got=%0d exp=1", a, b, c, lat44); end
          checks++; if (s41 !== exp_v) begin errors++; $display("FAIL sw41_sum a=%0d b=%0d c=%0d got=%0d exp=%0d", a, b, c, s41, exp_v); end
          checks++; if (s44 !== exp_v) begin errors++; $display("FAIL sw44_sum a=%0d b=%0d c=%0d got=%0d exp=%0d", a, b, c, s44, exp_v); end
        end
      end
    end
    if41.out_ready = 1'b0; if44.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.cin = 1'b0;  if8.out_ready = 1'b0;
    if41.in_valid = 1'b0; if41.a = '0; if41.b = '0; if41.cin = 1'b0; if41.out_ready = 1'b0;
    if44.in_valid = 1'b0; if44.a = '0; if44.b = '0; if44.cin = 1'b0; if44.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_signed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep_w4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
